// File: rtl/alu_mul_seq.sv
// Shift-and-add 8-bit multiply sequencer that borrows the shared ALU (ADD/LSH/RSH) one op per clock.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the shifted multiplier reaches zero.
module alu_mul_seq #(
   parameter int WIDTH = 8,
   parameter int ITERS = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Product,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic             AluSC,
   output logic [2:0]       AluOp,
   input  logic [WIDTH-1:0] AluOut,
   input  logic             AluZero,
   output logic [2:0]       dbg_state
);

   // Start/Done handshake: Start is sampled on any rising edge where Busy=0 (IDLE or DONE);
   // Done is a one-cycle pulse during which Product is already valid.

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADD  = 3'd1,
      S_SHL  = 3'd2,
      S_SHR  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LSH = 3'b001;
   localparam logic [2:0] OP_RSH = 3'b010;
   localparam logic [3:0] ITERS_LAST = 4'(ITERS);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

`ifndef MUL_EARLY_EXIT_EN
   logic unused_alu_zero;
   assign unused_alu_zero = AluZero;
`endif

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      m_d     = m_q;
      q_d     = q_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               m_d     = OpA;
               q_d     = OpB;
               p_d     = '0;
               cnt_d   = 4'd0;
               state_d = OpB[0] ? S_ADD : S_SHL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADD: begin
            p_d     = AluOut;
            state_d = S_SHL;
         end
         S_SHL: begin
            m_d     = AluOut;
            state_d = S_SHR;
         end
         S_SHR: begin
            q_d   = AluOut;
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == ITERS_LAST) begin
               state_d = S_DONE;
`ifdef MUL_EARLY_EXIT_EN
            end else if (AluZero) begin
               state_d = S_DONE;
`endif
            end else if (AluOut[0]) begin
               state_d = S_ADD;
            end else begin
               state_d = S_SHL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state and next register values, so the ALU
   // operands are already on the ports during the cycle the op is performed.
   always_comb begin
      alu_a_d   = '0;
      alu_b_d   = '0;
      alu_op_d  = OP_ADD;
      product_d = product_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_d)
         S_ADD: begin
            alu_a_d  = p_d;
            alu_b_d  = m_d;
            alu_op_d = OP_ADD;
            busy_d   = 1'b1;
         end
         S_SHL: begin
            alu_a_d  = m_d;
            alu_op_d = OP_LSH;
            busy_d   = 1'b1;
         end
         S_SHR: begin
            alu_a_d  = q_d;
            alu_op_d = OP_RSH;
            busy_d   = 1'b1;
         end
         S_DONE: begin
            product_d = p_d;
            done_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         p_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         cnt_q     <= 4'd0;
         product_q <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= OP_ADD;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         m_q       <= m_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Product   = product_q;
   assign AluA      = alu_a_q;
   assign AluB      = alu_b_q;
   assign AluSC     = 1'b0;
   assign AluOp     = alu_op_q;
   assign dbg_state = state_q;

endmodule
